bit_serial_add_ctrl: RTL and testbench
======================================

Name: bit_serial_add_ctrl

Overview:
- Sequencer that time-shares one 1-bit full-adder stage to add two WIDTH-bit operands serially, LSB first, one bit per clock.
- Carry is held in a flop between bit slots.
- Used where area matters more than latency: the block feeds the stage, collects sum bits, and reports completion over a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  in  1  single system clock; rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an addition; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is valid.
- sum  out  WIDTH  registered result; holds its value until the next completion.
- cout  out  1  registered final carry-out; holds its value until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; counter, carry flop and shift registers cleared.
- States:
  - IDLE: start=1 captures a, b, cin into the A/B shift regs and carry flop; counter=0; next state RUN.
  - RUN: each edge the stage adds A[0], B[0] and carry. The sum bit shifts into the MSB of the result shift reg. A and B shift right. Carry flop takes the stage carry. Counter increments.
    - When counter==WIDTH-1 on an edge, that edge processes the final bit. sum is loaded from the assembled shift reg, cout from the stage carry, and next state is DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1: capture new operands, go to RUN (back-to-back, no idle bubble).
    - start=0: go to IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high in the cycle after E_WIDTH. Total is WIDTH+1 cycles from start to done.
- busy=1 exactly in RUN, i.e. WIDTH cycles per operation.
- start during RUN is ignored and not queued. Operand inputs may change freely after capture.
- sum/cout are not touched during RUN; they show the previous result until the new one loads.
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of a+b+cin.
- Reset mid-RUN aborts the operation: no done pulse, sum/cout return to 0.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: B is captured inverted and the carry flop is seeded with 1, ignoring cin. The result is a-b mod 2^WIDTH, and cout=1 means no borrow.
  - sub=0: behaviour is identical to the block without the macro.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package bit_serial_pkg holds:
  - state enum type (IDLE, RUN, DONE), 2 bits;
  - localparam encodings;
  - a function computing CNT_W from WIDTH.
- One sub-module: fa_bit_stage, the combinational 1-bit full adder (inputs a, b, cin; outputs sum, carry), instantiated once.
- Controller FSM, counter, carry flop and shift registers stay in the top module.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, done at cycle 9, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- start held high continuously with a=0x01, b=0x02 -> done every 9 cycles, sum=0x03 each time. start pulses during RUN are ignored (busy never re-arms early).
- Complete op with result 0x96, start a new op, assert rst at RUN bit 4 -> sum=0x00, cout=0, busy=0 immediately, no done pulse. A fresh op after reset completes correctly.
- SERIAL_SUB_EN defined, sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. Then a=0x00, b=0x01 -> sum=0xFF, cout=0.
- Randomised 1000 ops at WIDTH=8 and WIDTH=13 against a reference model; sum/cout checked stable between done pulses.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared state encodings and sizing helper for the bit-serial adder
package bit_serial_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } state_t;

    // Bit-counter width: ceil(log2(width)), at least 1, for widths 2..32
    function automatic int calc_cnt_w(input int width);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << w) < width) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fa_bit_stage.sv
// rtl/fa_bit_stage.sv - combinational 1-bit full adder shared across all bit slots
module fa_bit_stage (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// rtl/bit_serial_add_ctrl.sv - LSB-first bit-serial adder sequencer; SERIAL_SUB_EN adds a subtract mode
module bit_serial_add_ctrl
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = calc_cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             stage_sum;
    logic             stage_carry;
    logic             sub_sel;
    logic [WIDTH-1:0] b_load;
    logic             carry_seed;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so invert B and force the initial carry high
    assign b_load     = sub_sel ? ~b : b;
    assign carry_seed = sub_sel | cin;
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign res_next   = {stage_sum, res_sh[WIDTH-1:1]};

    fa_bit_stage u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (stage_sum),
        .carry (stage_carry)
    );

    // Controller: capture operands, step one bit per clock, publish result on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_seed;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= stage_carry;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum   <= res_next;
                        cout  <= stage_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// tb/tb_bit_serial_add_ctrl.sv - randomized self-checking bench for bit_serial_add_ctrl at WIDTH 8 and 13
module tb_bit_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, cin8, sub8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start13, cin13, sub13, busy13, done13, cout13;
    logic [12:0] a13, b13, sum13;

`ifdef SERIAL_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Last result each instance should be holding (index 0: WIDTH 8, index 1: WIDTH 13)
    logic [31:0] exp_sum  [2];
    logic        exp_cout [2];

    bit_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    bit_serial_add_ctrl #(.WIDTH(13)) u_dut13 (
        .clk   (clk),
        .rst   (rst),
        .start (start13),
        .a     (a13),
        .b     (b13),
        .cin   (cin13),
`ifdef SERIAL_SUB_EN
        .sub   (sub13),
`endif
        .busy  (busy13),
        .done  (done13),
        .sum   (sum13),
        .cout  (cout13)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic st, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb);
        if (s == 0) begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; sub8 = sb;
        end else begin
            start13 = st; a13 = av[12:0]; b13 = bv[12:0]; cin13 = ci; sub13 = sb;
        end
    endtask

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy8 : busy13;
    endfunction

    function automatic logic get_done(input int s);
        return (s == 0) ? done8 : done13;
    endfunction

    function automatic logic get_cout(input int s);
        return (s == 0) ? cout8 : cout13;
    endfunction

    function automatic logic [31:0] get_sum(input int s);
        return (s == 0) ? {24'd0, sum8} : {19'd0, sum13};
    endfunction

    // Reference: plain integer arithmetic; returns {cout, sum}
    function automatic logic [32:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic sb);
        longint unsigned mask, x, y, t;
        logic [31:0] s_v;
        logic        c_v;
        mask = (64'd1 << w) - 64'd1;
        x = {32'd0, av} & mask;
        y = {32'd0, bv} & mask;
        if (sb) begin
            t   = (x - y) & mask;
            s_v = t[31:0];
            c_v = (x >= y);
        end else begin
            t   = x + y + {63'd0, ci};
            s_v = 32'(t & mask);
            c_v = t[w];
        end
        return {c_v, s_v};
    endfunction

    function automatic logic rand_sub();
        return HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // One operation: start, observe RUN (optionally toggling start and operands), check the done cycle
    task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, input bit noisy, input string tag);
        int          w;
        int          edges;
        int          nbusy;
        bit          stable;
        logic [32:0] m;
        w      = (s == 0) ? 8 : 13;
        m      = model(w, av, bv, ci, sb);
        stable = 1'b1;
        nbusy  = 0;
        drive(s, 1'b1, av, bv, ci, sb);
        tick();
        edges = 1;
        while (!get_done(s) && edges < 4 * w + 8) begin
            nbusy += int'(get_busy(s));
            if (get_sum(s) !== exp_sum[s] || get_cout(s) !== exp_cout[s]) begin
                stable = 1'b0;
            end
            if (noisy) begin
                drive(s, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), rand_sub());
            end else begin
                drive(s, 1'b0, av, bv, ci, sb);
            end
            tick();
            edges++;
        end
        drive(s, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), rand_sub());
        check({tag, "_done"},    32'(get_done(s)), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(w + 1));
        check({tag, "_busy_n"},  32'(nbusy), 32'(w));
        check({tag, "_busy_lo"}, 32'(get_busy(s)), 32'd0);
        check({tag, "_hold"},    32'(stable), 32'd1);
        check({tag, "_sum"},     get_sum(s), m[31:0]);
        check({tag, "_cout"},    32'(get_cout(s)), 32'(m[32]));
        exp_sum[s]  = m[31:0];
        exp_cout[s] = m[32];
    endtask

    initial begin
        int ndone;
        int nb;
        int gap;
        rst = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        exp_sum[0] = '0; exp_sum[1] = '0;
        exp_cout[0] = 1'b0; exp_cout[1] = 1'b0;
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
            check("reset_busy", 32'(get_busy(s)), 32'd0);
            check("reset_done", 32'(get_done(s)), 32'd0);
            check("reset_sum",  get_sum(s), 32'd0);
            check("reset_cout", 32'(get_cout(s)), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Directed additions
        run_op(0, 32'h5A, 32'h3C, 1'b0, 1'b0, 1'b0, "add_5a_3c");
        run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
        run_op(0, 32'hFF, 32'h00, 1'b1, 1'b0, 1'b0, "add_ff_00_c");
        tick();
        check("done_pulse_once", 32'(done8), 32'd0);

`ifdef SERIAL_SUB_EN
        run_op(0, 32'h10, 32'h01, 1'b0, 1'b1, 1'b0, "sub_10_01");
        run_op(0, 32'h00, 32'h01, 1'b1, 1'b1, 1'b0, "sub_00_01");
        tick();
`endif

        // Start held high: back-to-back operations every WIDTH+1 cycles
        drive(0, 1'b1, 32'h01, 32'h02, 1'b0, 1'b0);
        ndone = 0;
        nb    = 0;
        for (int t = 1; t <= 27; t++) begin
            tick();
            nb += int'(busy8);
            if (done8) begin
                ndone++;
                check("b2b_period", 32'(t), 32'(9 * ndone));
                check("b2b_sum", {24'd0, sum8}, 32'h03);
            end
        end
        drive(0, 1'b0, 32'h01, 32'h02, 1'b0, 1'b0);
        check("b2b_count", 32'(ndone), 32'd3);
        check("b2b_busy", 32'(nb), 32'd24);
        exp_sum[0]  = 32'h03;
        exp_cout[0] = 1'b0;
        tick();

        // Reset in the middle of RUN aborts the operation
        run_op(0, 32'h5A, 32'h3C, 1'b0, 1'b0, 1'b0, "pre_rst");
        drive(0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0);
        repeat (4) tick();
        check("rst_run_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_sum",  {24'd0, sum8}, 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        exp_sum[0] = '0; exp_sum[1] = '0;
        exp_cout[0] = 1'b0; exp_cout[1] = 1'b0;
        repeat (2) begin
            tick();
            check("rst_no_done", 32'(done8), 32'd0);
        end
        rst = 1'b0;
        tick();
        run_op(0, 32'hA7, 32'h6D, 1'b1, 1'b0, 1'b0, "post_rst");

        // Randomized operations on both widths, with start noise and operand churn during RUN
        for (int i = 0; i < 1000; i++) begin
            for (int s = 0; s < 2; s++) begin
                run_op(s, $urandom, $urandom, 1'($urandom_range(0, 1)), rand_sub(), 1'b1,
                       (s == 0) ? "rnd8" : "rnd13");
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    tick();
                    check("rnd_done_pulse", 32'(get_done(s)), 32'd0);
                    if (gap > 1) tick();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
